// File: rtl/matrix_result_printer.sv
// Streams a signed result matrix to a UART transmitter as decimal ASCII text.
// Elements are read row-major from a 1-cycle-latency buffer. Elements in a row
// are separated by spaces, and each row ends with CR LF.
module matrix_result_printer #(
    parameter int DATA_W = 16,
    parameter int DIM_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  res_m,
    input  logic [DIM_W-1:0]  res_n,
    output logic [DIM_W-1:0]  rd_row,
    output logic [DIM_W-1:0]  rd_col,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_RD, CONV, SEND_SIGN, SEND_DIGIT,
        SEND_SEP, SEND_CR, SEND_LF, FINISH
    } state_t;

    localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0]  DIM_ZERO = {DIM_W{1'b0}};
    localparam logic [DATA_W-1:0] DAT_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t             state_r, state_nxt_s;
    logic [DIM_W-1:0]   m_r, m_nxt_s, n_r, n_nxt_s;
    logic [DIM_W-1:0]   row_r, row_nxt_s, col_r, col_nxt_s;
    logic [DATA_W-1:0]  mag_r, mag_nxt_s;
    logic               neg_r, neg_nxt_s;
    logic [2:0]         conv_idx_r, conv_idx_nxt_s;
    logic [3:0]         cnt_r, cnt_nxt_s;
    logic [4:0][3:0]    digit_r, digit_nxt_s;
    logic [2:0]         dig_idx_r, dig_idx_nxt_s;
    logic [7:0]         tx_data_r, tx_data_nxt_s;
    logic               tx_valid_r, tx_valid_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic [31:0]        mag_ext_s, weight_s;
    logic [DATA_W-1:0]  abs_s;
    logic [7:0]         byte_s;

    // Decimal weight used by the subtraction step for each digit position.
    function automatic logic [31:0] digit_weight(input logic [2:0] idx);
        case (idx)
            3'd0:    digit_weight = 32'd10000;
            3'd1:    digit_weight = 32'd1000;
            3'd2:    digit_weight = 32'd100;
            3'd3:    digit_weight = 32'd10;
            default: digit_weight = 32'd1;
        endcase
    endfunction

    // Index of the first non-zero digit; the units digit is always printed.
    function automatic logic [2:0] lead_index(input logic [4:0][3:0] d);
        lead_index = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (d[i] != 4'd0) begin
                lead_index = 3'(i);
            end else begin
                lead_index = lead_index;
            end
        end
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_nxt_s    = state_r;
        m_nxt_s        = m_r;
        n_nxt_s        = n_r;
        row_nxt_s      = row_r;
        col_nxt_s      = col_r;
        mag_nxt_s      = mag_r;
        neg_nxt_s      = neg_r;
        conv_idx_nxt_s = conv_idx_r;
        cnt_nxt_s      = cnt_r;
        digit_nxt_s    = digit_r;
        dig_idx_nxt_s  = dig_idx_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        mag_ext_s      = {{(32-DATA_W){1'b0}}, mag_r};
        weight_s       = digit_weight(conv_idx_r);
        abs_s          = rd_data[DATA_W-1] ? (~rd_data + DAT_ONE) : rd_data;

        case (state_r)
            SEND_SIGN:  byte_s = 8'h2D;
            SEND_DIGIT: byte_s = 8'h30 + {4'h0, digit_r[dig_idx_r]};
            SEND_SEP:   byte_s = 8'h20;
            SEND_CR:    byte_s = 8'h0D;
            SEND_LF:    byte_s = 8'h0A;
            default:    byte_s = 8'h00;
        endcase

        case (state_r)
            IDLE: begin
                if (start) begin
                    m_nxt_s   = res_m;
                    n_nxt_s   = res_n;
                    row_nxt_s = DIM_ZERO;
                    col_nxt_s = DIM_ZERO;
                    if ((res_m == DIM_ZERO) || (res_n == DIM_ZERO)) begin
                        state_nxt_s = FINISH;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: state_nxt_s = WAIT_RD;
            WAIT_RD: begin
                mag_nxt_s      = abs_s;
                neg_nxt_s      = rd_data[DATA_W-1];
                conv_idx_nxt_s = 3'd0;
                cnt_nxt_s      = 4'd0;
                digit_nxt_s    = '0;
                state_nxt_s    = CONV;
            end
            CONV: begin
                if (conv_idx_r < 3'd4) begin
                    if (mag_ext_s >= weight_s) begin
                        mag_nxt_s = mag_r - weight_s[DATA_W-1:0];
                        cnt_nxt_s = cnt_r + 4'd1;
                    end else begin
                        digit_nxt_s[conv_idx_r] = cnt_r;
                        cnt_nxt_s               = 4'd0;
                        conv_idx_nxt_s          = conv_idx_r + 3'd1;
                    end
                end else begin
                    digit_nxt_s[4] = mag_r[3:0];
                    dig_idx_nxt_s  = lead_index(digit_nxt_s);
                    state_nxt_s    = neg_r ? SEND_SIGN : SEND_DIGIT;
                end
            end
            SEND_SIGN, SEND_DIGIT, SEND_SEP, SEND_CR, SEND_LF: begin
                if (!tx_valid_r) begin
                    tx_valid_nxt_s = 1'b1;
                    tx_data_nxt_s  = byte_s;
                end else if (tx_ready) begin
                    tx_valid_nxt_s = 1'b0;
                    case (state_r)
                        SEND_SIGN: state_nxt_s = SEND_DIGIT;
                        SEND_DIGIT: begin
                            if (dig_idx_r == 3'd4) begin
                                state_nxt_s = (col_r == n_r - DIM_ONE) ? SEND_CR : SEND_SEP;
                            end else begin
                                dig_idx_nxt_s = dig_idx_r + 3'd1;
                            end
                        end
                        SEND_SEP: begin
                            col_nxt_s   = col_r + DIM_ONE;
                            state_nxt_s = FETCH;
                        end
                        SEND_CR: state_nxt_s = SEND_LF;
                        SEND_LF: begin
                            if (row_r == m_r - DIM_ONE) begin
                                state_nxt_s = FINISH;
                            end else begin
                                row_nxt_s   = row_r + DIM_ONE;
                                col_nxt_s   = DIM_ZERO;
                                state_nxt_s = FETCH;
                            end
                        end
                        default: state_nxt_s = IDLE;
                    endcase
                end else begin
                    tx_valid_nxt_s = 1'b1;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase

        busy_nxt_s = (state_nxt_s != IDLE) && (state_nxt_s != FINISH);
        done_nxt_s = (state_nxt_s == FINISH);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            m_r        <= '0;
            n_r        <= '0;
            row_r      <= '0;
            col_r      <= '0;
            mag_r      <= '0;
            neg_r      <= 1'b0;
            conv_idx_r <= 3'd0;
            cnt_r      <= 4'd0;
            digit_r    <= '0;
            dig_idx_r  <= 3'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            m_r        <= m_nxt_s;
            n_r        <= n_nxt_s;
            row_r      <= row_nxt_s;
            col_r      <= col_nxt_s;
            mag_r      <= mag_nxt_s;
            neg_r      <= neg_nxt_s;
            conv_idx_r <= conv_idx_nxt_s;
            cnt_r      <= cnt_nxt_s;
            digit_r    <= digit_nxt_s;
            dig_idx_r  <= dig_idx_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign rd_row   = row_r;
    assign rd_col   = col_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
